// File: rtl/irrigation_pump_scheduler.sv
// rtl/irrigation_pump_scheduler.sv - round-robin pump/valve sequencer for shared tank; `PUMP_COOLDOWN_EN adds REST
module irrigation_pump_scheduler #(
  parameter int ZONES    = 4,
  parameter int GUARD    = 2,
  parameter int MIN_ON   = 8,
  parameter int MAX_ON   = 64,
  parameter int COOLDOWN = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [ZONES-1:0] zone_request,
  input  logic             low_level,
  input  logic             empty_tank,
  input  logic             fertilise_push,
  output logic             pump_on,
  output logic [ZONES-1:0] valve_open,
  output logic             sprinkling,
  output logic             fertilise_grant,
  output logic             busy,
  output logic             alarm
);

  localparam int ZW  = $clog2(ZONES);
  localparam int ZW1 = ZW + 1;
  // One counter serves guard, pump-on and rest timing, so size it for the largest
  localparam int CW  = $clog2(MAX_ON + GUARD + COOLDOWN + 1) + 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_OPEN  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_CLOSE = 3'd3;
`ifdef PUMP_COOLDOWN_EN
  localparam logic [2:0] ST_REST  = 3'd4;
  localparam logic [CW-1:0] COOL_LAST = CW'(COOLDOWN - 1);
`endif

  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);
  localparam logic [CW-1:0] MIN_LAST   = CW'(MIN_ON - 1);
  localparam logic [CW-1:0] MAX_LAST   = CW'(MAX_ON - 1);
  localparam logic [ZW:0]   ZONES_W    = ZW1'(ZONES);
  localparam logic [ZW-1:0] LAST_ZONE  = ZW'(ZONES - 1);

  logic [2:0]    state_q, state_d;
  logic [ZW-1:0] cur_q, cur_d;
  logic [ZW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fg_q, fg_d;

  logic          fault;
  logic [ZW-1:0] pick;
  logic [ZW:0]   idx;
  logic          found;
  logic          run_exit;
  logic [ZW-1:0] next_ptr;

  assign fault    = low_level | empty_tank;
  assign next_ptr = (cur_q == LAST_ZONE) ? '0 : cur_q + ZW'(1);
  assign run_exit = fault
                  || ((cnt_q >= MIN_LAST) && !zone_request[cur_q])
                  || (cnt_q == MAX_LAST);

  // Round-robin pick: first requesting zone at or after the pointer, wrapping
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < ZONES; k++) begin
      idx = {1'b0, ptr_q} + ZW1'(k);
      if (idx >= ZONES_W) idx = idx - ZONES_W;
      if (!found && zone_request[idx[ZW-1:0]]) begin
        pick  = idx[ZW-1:0];
        found = 1'b1;
      end
    end
  end

  // Next-state: valve guard, pump run with min/max limits, close guard
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        // A fault seen in the decision cycle blocks the grant
        if (found && !fault) begin
          state_d = ST_OPEN;
          cur_d   = pick;
          cnt_d   = '0;
        end
      end
      ST_OPEN: begin
        if (fault) begin
          state_d = ST_CLOSE;
          cnt_d   = '0;
        end else if (cnt_q == GUARD_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RUN: begin
        if (run_exit) begin
          state_d = ST_CLOSE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_CLOSE: begin
        if (cnt_q == GUARD_LAST) begin
          ptr_d = next_ptr;
          cnt_d = '0;
`ifdef PUMP_COOLDOWN_EN
          state_d = ST_REST;
`else
          state_d = ST_IDLE;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef PUMP_COOLDOWN_EN
      ST_REST: begin
        // Rest runs its full length even under a fault
        if (cnt_q == COOL_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Fertiliser permission is sticky while RUN continues and drops with the pump
  always_comb begin
    fg_d = (state_q == ST_RUN) && (state_d == ST_RUN)
        && (fg_q || (fertilise_push && !low_level));
  end

  // State registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      fg_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      fg_q    <= fg_d;
    end
  end

  // Output decode from registered state; alarm alone looks at live inputs
  always_comb begin
    pump_on         = (state_q == ST_RUN);
    sprinkling      = (state_q == ST_RUN);
    busy            = (state_q != ST_IDLE);
    fertilise_grant = fg_q;
    valve_open      = '0;
    if (state_q == ST_OPEN || state_q == ST_RUN || state_q == ST_CLOSE)
      valve_open = ZONES'(1) << cur_q;
    alarm = (fault && (|zone_request)) || (fertilise_push && (state_q != ST_RUN));
  end

endmodule

// File: tb/tb_irrigation_pump_scheduler.sv
// tb/tb_irrigation_pump_scheduler.sv - directed self-checking bench for irrigation_pump_scheduler
module tb_irrigation_pump_scheduler;

  localparam int ZONES = 4;

  logic             clk;
  logic             reset;
  logic [ZONES-1:0] zone_request;
  logic             low_level;
  logic             empty_tank;
  logic             fertilise_push;
  logic             pump_on;
  logic [ZONES-1:0] valve_open;
  logic             sprinkling;
  logic             fertilise_grant;
  logic             busy;
  logic             alarm;

  int n_checks = 0;
  int n_errors = 0;

  irrigation_pump_scheduler #(
    .ZONES(4), .GUARD(2), .MIN_ON(8), .MAX_ON(64), .COOLDOWN(4)
  ) dut (
    .clock          (clk),
    .reset          (reset),
    .zone_request   (zone_request),
    .low_level      (low_level),
    .empty_tank     (empty_tank),
    .fertilise_push (fertilise_push),
    .pump_on        (pump_on),
    .valve_open     (valve_open),
    .sprinkling     (sprinkling),
    .fertilise_grant(fertilise_grant),
    .busy           (busy),
    .alarm          (alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    zone_request   = '0;
    low_level      = 1'b0;
    empty_tank     = 1'b0;
    fertilise_push = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_pump(input string tag);
    int t;
    t = 0;
    while (!pump_on && t < 20) begin @(negedge clk); t++; end
    check(tag, 32'(t < 20), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (busy && t < 200) begin @(negedge clk); t++; end
    check(tag, 32'(t < 200), 32'd1);
  endtask

  // Follow one grant: 2 open cycles, plen pump cycles, 2 close cycles, then idle
  task automatic serve(input int zone, input int plen);
    int t, o, p, c;
    logic [ZONES-1:0] hot;
    hot = ZONES'(1 << zone);
    t = 0;
    while (valve_open == '0 && t < 20) begin @(negedge clk); t++; end
    check("grant_seen", 32'(t < 20), 32'd1);
    check("grant_zone", 32'(valve_open), 32'(hot));
    o = 0;
    while (valve_open == hot && !pump_on && o < 10) begin @(negedge clk); o++; end
    check("open_len", 32'(o), 32'd2);
    p = 0;
    while (pump_on && valve_open == hot && p < 200) begin @(negedge clk); p++; end
    check("pump_len", 32'(p), 32'(plen));
    c = 0;
    while (valve_open == hot && !pump_on && c < 10) begin @(negedge clk); c++; end
    check("close_len", 32'(c), 32'd2);
    check("idle_valve", 32'(valve_open), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int p;
    logic g_ok;

    // Reset state
    do_reset();
    check("rst_pump", 32'(pump_on), 32'd0);
    check("rst_valve", 32'(valve_open), 32'd0);
    check("rst_sprink", 32'(sprinkling), 32'd0);
    check("rst_fgrant", 32'(fertilise_grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_alarm", 32'(alarm), 32'd0);

    // Single zone held: MAX_ON run, then regrant to the same zone
    zone_request = 4'b0001;
    serve(0, 64);
    serve(0, 64);
    zone_request = 4'b0000;
    @(negedge clk);

    // Round-robin with 1011 held
    do_reset();
    zone_request = 4'b1011;
    serve(0, 64);
    serve(1, 64);
    serve(3, 64);
    serve(0, 64);
    zone_request = 4'b0000;
    @(negedge clk);

    // Minimum run: one-cycle request on zone 2
    do_reset();
    zone_request = 4'b0100;
    @(negedge clk);
    zone_request = 4'b0000;
    serve(2, 8);

    // Fault mid-run: empty_tank at pump cycle 3
    do_reset();
    zone_request = 4'b0001;
    wait_pump("fault_pump_seen");
    repeat (3) @(negedge clk);
    empty_tank = 1'b1;
    #1;
    check("fault_alarm", 32'(alarm), 32'd1);
    check("fault_pump_still", 32'(pump_on), 32'd1);
    @(negedge clk);
    check("fault_pump_off", 32'(pump_on), 32'd0);
    check("fault_close1", 32'(valve_open), 32'b0001);
    @(negedge clk);
    check("fault_close2", 32'(valve_open), 32'b0001);
    @(negedge clk);
    check("fault_valve_off", 32'(valve_open), 32'd0);
    repeat (3) @(negedge clk);
    check("fault_no_grant", 32'(busy), 32'd0);
    check("fault_alarm_idle", 32'(alarm), 32'd1);
    zone_request = 4'b0000;
    #1;
    check("fault_alarm_noreq", 32'(alarm), 32'd0);
    empty_tank = 1'b0;
    @(negedge clk);

    // Fertilise pulse during RUN, then push while idle
    do_reset();
    zone_request = 4'b0001;
    @(negedge clk);
    zone_request = 4'b0000;
    wait_pump("fert_pump_seen");
    @(negedge clk);
    fertilise_push = 1'b1;
    #1;
    check("fert_alarm_run", 32'(alarm), 32'd0);
    @(negedge clk);
    fertilise_push = 1'b0;
    check("fert_set", 32'(fertilise_grant), 32'd1);
    g_ok = 1'b1;
    p = 0;
    while (pump_on && p < 50) begin
      if (!fertilise_grant) g_ok = 1'b0;
      @(negedge clk);
      p++;
    end
    check("fert_hold", 32'(g_ok), 32'd1);
    check("fert_pump_rest", 32'(p), 32'd6);
    check("fert_clear", 32'(fertilise_grant), 32'd0);
    wait_idle("fert_idle");
    fertilise_push = 1'b1;
    #1;
    check("fert_idle_alarm", 32'(alarm), 32'd1);
    check("fert_idle_grant", 32'(fertilise_grant), 32'd0);
    @(negedge clk);
    check("fert_idle_grant2", 32'(fertilise_grant), 32'd0);
    check("fert_idle_busy", 32'(busy), 32'd0);
    fertilise_push = 1'b0;

    // Async reset mid-run; pointer advanced to 1 beforehand, must return to 0
    do_reset();
    zone_request = 4'b0001;
    @(negedge clk);
    zone_request = 4'b0000;
    wait_pump("ar_first_pump");
    wait_idle("ar_first_idle");
    zone_request = 4'b0001;
    wait_pump("ar_pump_seen");
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("ar_pump", 32'(pump_on), 32'd0);
    check("ar_valve", 32'(valve_open), 32'd0);
    check("ar_sprink", 32'(sprinkling), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_fgrant", 32'(fertilise_grant), 32'd0);
    check("ar_alarm", 32'(alarm), 32'd0);
    zone_request = 4'b0101;
    @(negedge clk);
    reset = 1'b0;
    serve(0, 64);
    zone_request = 4'b0100;
    serve(2, 64);
    zone_request = 4'b0000;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
